// File: rtl/rc5_pkg.sv
// Shared RC5 constants, FSM state encoding and key-word count helper.
package rc5_pkg;

    localparam logic [31:0] P32 = 32'hB7E15163;
    localparam logic [31:0] Q32 = 32'h9E3779B9;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        INIT,
        MIX,
        DONE
    } state_t;

    // Number of w-bit words needed to hold a b-byte key, never less than one.
    function automatic int calc_c(input int b, input int w);
        int n;
        n = (8 * b + w - 1) / w;
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/rc5_rotl.sv
// Combinational barrel left-rotate, shared with the RC5 cipher datapath.
module rc5_rotl #(
    parameter int w = 32
) (
    input  logic [w-1:0]         x,
    input  logic [$clog2(w)-1:0] amt,
    output logic [w-1:0]         y
);

    logic [2*w-1:0] dbl;

    // Shifting a doubled copy leaves the rotated word in the upper half.
    always_comb begin
        dbl = {x, x} << amt;
        y   = dbl[2*w-1:w];
    end

endmodule

// File: rtl/rc5_key_expand.sv
// RC5 key schedule: word-serial key load, S table init and 3-pass mix,
// then a combinational pair read port for the cipher/decipher datapath.
module rc5_key_expand
    import rc5_pkg::*;
#(
    parameter int w        = 32,
    parameter int r        = 12,
    parameter int b        = 16,
    parameter int t        = 2 * r + 2,
    parameter int c        = calc_c(b, w),
    parameter int t_length = $clog2(t)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [w-1:0]        key_word,
    input  logic                key_valid,
    output logic                key_ready,
    output logic                busy,
    output logic                ready,
    input  logic [t_length-1:0] S_address,
    output logic [w-1:0]        S_sub_i1,
    output logic [w-1:0]        S_sub_i2
);

    localparam int MIX_N = 3 * ((t > c) ? t : c);
    localparam int JW    = (c > 1) ? $clog2(c) : 1;
    localparam int KW    = $clog2(MIX_N);
    localparam int LG    = $clog2(w);

    localparam logic [t_length-1:0] I_LAST = t_length'(t - 1);
    localparam logic [t_length-1:0] I_ONE  = t_length'(1);
    localparam logic [t_length:0]   T_EXT  = (t_length + 1)'(t);
    localparam logic [JW-1:0]       J_LAST = JW'(c - 1);
    localparam logic [JW-1:0]       J_ONE  = JW'(1);
    localparam logic [KW-1:0]       K_LAST = KW'(MIX_N - 1);
    localparam logic [KW-1:0]       K_ONE  = KW'(1);

    state_t state, state_next;

    logic [t_length-1:0] i;
    logic [JW-1:0]       j;
    logic [KW-1:0]       k;
    logic [w-1:0]        a_reg, b_reg;
    logic [w-1:0]        s_mem [t];
    logic [w-1:0]        l_mem [c];

    logic                accept;
    logic [t_length-1:0] i_prev;
    logic [w-1:0]        init_val;
    logic [w-1:0]        a_sum, a_new, ab_sum, b_sum, b_new;
    logic [t_length-1:0] addr_next;
    logic                read_ok1, read_ok2;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // NOTE: sequential state is assigned with <= so every register in the
    // design samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // NOTE: every output of this block is given a default first, so no
    // path through the case leaves a signal unassigned and latches it.
    always_comb begin
        state_next = state;
        key_ready  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE, LOAD, DONE: begin
                key_ready = 1'b1;
                if (key_valid) state_next = (j == J_LAST) ? INIT : LOAD;
            end
            INIT: begin
                busy = 1'b1;
                if (i == I_LAST) state_next = MIX;
            end
            MIX: begin
                busy = 1'b1;
                if (k == K_LAST) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = key_valid && key_ready;

    // ------------------------------------------------------------------
    // Init and mix arithmetic
    // ------------------------------------------------------------------
    assign i_prev   = i - I_ONE;
    assign init_val = (i == '0) ? w'(P32) : s_mem[i_prev] + w'(Q32);
    assign a_sum    = s_mem[i] + a_reg + b_reg;
    assign ab_sum   = a_new + b_reg;
    assign b_sum    = l_mem[j] + ab_sum;

    rc5_rotl #(.w(w)) u_rotl_a (
        .x   (a_sum),
        .amt (LG'(3)),
        .y   (a_new)
    );

    rc5_rotl #(.w(w)) u_rotl_b (
        .x   (b_sum),
        .amt (ab_sum[LG-1:0]),
        .y   (b_new)
    );

    // ------------------------------------------------------------------
    // Counters, A/B registers and the ready level
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            i     <= '0;
            j     <= '0;
            k     <= '0;
            a_reg <= '0;
            b_reg <= '0;
            ready <= 1'b0;
        end else begin
            // Rises one edge after DONE is reached; a new key word drops it.
            ready <= (state == DONE) && !accept;
            case (state)
                IDLE, LOAD, DONE: begin
                    if (accept) begin
                        if (j == J_LAST) begin
                            j <= '0;
                            i <= '0;
                        end else begin
                            j <= j + J_ONE;
                        end
                    end
                end
                INIT: begin
                    if (i == I_LAST) begin
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                        a_reg <= '0;
                        b_reg <= '0;
                    end else begin
                        i <= i + I_ONE;
                    end
                end
                MIX: begin
                    a_reg <= a_new;
                    b_reg <= b_new;
                    i     <= (i == I_LAST) ? '0 : i + I_ONE;
                    if (k == K_LAST) begin
                        // j restarts at L[0] so a rekey overwrites from the start.
                        j <= '0;
                        k <= '0;
                    end else begin
                        j <= (j == J_LAST) ? '0 : j + J_ONE;
                        k <= k + K_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the S and L arrays are not reset; their contents are only
    // exposed after a full init/mix run, so plain RAM writes suffice.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (accept)              l_mem[j] <= key_word;
            else if (state == MIX)   l_mem[j] <= b_new;
            if (state == INIT)       s_mem[i] <= init_val;
            else if (state == MIX)   s_mem[i] <= a_new;
        end
    end

    // ------------------------------------------------------------------
    // Pair read port, zero outside the table or while not ready
    // ------------------------------------------------------------------
    assign addr_next = S_address + I_ONE;
    assign read_ok1  = {1'b0, S_address} < T_EXT;
    assign read_ok2  = S_address < I_LAST;

    always_comb begin
        S_sub_i1 = '0;
        S_sub_i2 = '0;
        if (ready && read_ok1) S_sub_i1 = s_mem[S_address];
        if (ready && read_ok2) S_sub_i2 = s_mem[addr_next];
    end

endmodule

// File: tb/tb_rc5_key_expand.sv
// Scoreboard bench for rc5_key_expand: randomized keys against a software RC5 schedule.
module tb_rc5_key_expand;

    localparam int T = 26;
    localparam int C = 4;
    localparam int R = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] key_word = '0;
    logic        key_valid = 1'b0;
    logic        key_ready, busy, ready;
    logic [4:0]  S_address = '0;
    logic [31:0] S_sub_i1, S_sub_i2;

    always #50 clk = ~clk;

    rc5_key_expand dut (
        .clk       (clk),
        .rst       (rst),
        .key_word  (key_word),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .busy      (busy),
        .ready     (ready),
        .S_address (S_address),
        .S_sub_i1  (S_sub_i1),
        .S_sub_i2  (S_sub_i2)
    );

    typedef struct packed {
        logic [25:0][31:0] s;
        logic [31:0]       acc;
        logic              zk;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   tgt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rol(input logic [31:0] x, input logic [31:0] n);
        int sh;
        sh = int'(n[4:0]);
        if (sh == 0) return x;
        return (x << sh) | (x >> (32 - sh));
    endfunction

    function automatic logic [31:0] ror(input logic [31:0] x, input logic [31:0] n);
        int sh;
        sh = int'(n[4:0]);
        if (sh == 0) return x;
        return (x >> sh) | (x << (32 - sh));
    endfunction

    // Textbook RC5 key expansion.
    function automatic logic [25:0][31:0] model(input logic [3:0][31:0] key);
        logic [25:0][31:0] s;
        logic [3:0][31:0]  l;
        logic [31:0]       a, bb;
        int                ii, jj;
        l    = key;
        s[0] = 32'hB7E15163;
        for (int n = 1; n < T; n++) s[n] = s[n-1] + 32'h9E3779B9;
        a = '0; bb = '0; ii = 0; jj = 0;
        for (int n = 0; n < 3 * T; n++) begin
            a     = rol(s[ii] + a + bb, 32'd3);
            s[ii] = a;
            bb    = rol(l[jj] + a + bb, a + bb);
            l[jj] = bb;
            ii    = (ii + 1) % T;
            jj    = (jj + 1) % C;
        end
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Monitor: pops the scoreboard on every rising ready
    // ------------------------------------------------------------------
    exp_t        mon_e;
    logic [31:0] rd1 [32];
    logic [31:0] rd2 [32];
    int          busy_cnt = 0;
    logic        prev_ready = 1'b0;

    always @(negedge clk) begin
        logic        r_now;
        logic [31:0] e1, e2, da, db;
        r_now = ready;
        if (!rst) busy_cnt = 0;
        else if (busy) busy_cnt++;
        if (r_now && !prev_ready) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_ready: got ready=1, expected no pending key");
            end else begin
                mon_e = sb_q.pop_front();
                check("latency", cyc - int'(mon_e.acc), 32'd105);
                check("busy_cycles", busy_cnt, 32'd104);
                for (int a = 0; a < 32; a++) begin
                    S_address = a[4:0];
                    #1;
                    e1 = (a < T)     ? mon_e.s[a]     : 32'h0;
                    e2 = (a < T - 1) ? mon_e.s[a + 1] : 32'h0;
                    rd1[a] = S_sub_i1;
                    rd2[a] = S_sub_i2;
                    check($sformatf("S_sub_i1[%0d]", a), S_sub_i1, e1);
                    check($sformatf("S_sub_i2[%0d]", a), S_sub_i2, e2);
                end
                if (mon_e.zk) begin
                    da = 32'hEEDBA521;
                    db = 32'h6D8F4B15;
                    for (int n = R; n >= 1; n--) begin
                        db = ror(db - rd2[2*n], da) ^ da;
                        da = ror(da - rd1[2*n], db) ^ db;
                    end
                    db = db - rd2[0];
                    da = da - rd1[0];
                    check("decipher_A", da, 32'h0);
                    check("decipher_B", db, 32'h0);
                end
            end
            busy_cnt = 0;
            done_cnt++;
        end else if (!r_now) begin
            S_address = 5'($urandom_range(0, 31));
            #1;
            check("idle_S_sub_i1", S_sub_i1, 32'h0);
            check("idle_S_sub_i2", S_sub_i2, 32'h0);
        end
        prev_ready = r_now;
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic load_key(input logic [3:0][31:0] kw, input logic [3:0][3:0] gap,
                            input bit zk, input bit rekey, input bit noise);
        exp_t e;
        if (rekey) check("ready_before_rekey", ready, 1'b1);
        for (int n = 0; n < C; n++) begin
            key_valid = 1'b0;
            repeat (int'(gap[n])) begin
                @(posedge clk);
                #1;
            end
            key_valid = 1'b1;
            key_word  = kw[n];
            check("key_ready_load", key_ready, 1'b1);
            @(posedge clk);
            #1;
            if (rekey && n == 0) check("ready_drop_rekey", ready, 1'b0);
        end
        key_valid = 1'b0;
        e.s   = model(kw);
        e.acc = cyc;
        e.zk  = zk;
        sb_q.push_back(e);
        if (noise) begin
            repeat (90) begin
                key_valid = 1'($urandom_range(0, 1));
                key_word  = $urandom;
                @(posedge clk);
                #1;
                check("key_ready_busy", key_ready, 1'b0);
                check("busy_high", busy, 1'b1);
            end
            key_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int target);
        int g = 0;
        while (done_cnt < target && g < 400) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("run_complete", done_cnt, target);
    endtask

    initial begin
        logic [3:0][31:0] zero_key, seq_key, rnd_key;
        logic [3:0][3:0]  no_gap, some_gap, rnd_gap;

        zero_key = '0;
        seq_key  = {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100};
        no_gap   = '0;
        some_gap = {4'd5, 4'd1, 4'd0, 4'd0};

        rst       = 1'b0;
        key_valid = 1'b1;
        key_word  = $urandom;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_key_ready", key_ready, 1'b1);
            check("rst_busy", busy, 1'b0);
            check("rst_ready", ready, 1'b0);
        end
        key_valid = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;

        load_key(zero_key, no_gap, 1'b1, 1'b0, 1'b0);
        tgt++;
        wait_done(tgt);

        load_key(seq_key, no_gap, 1'b0, 1'b1, 1'b0);
        tgt++;
        wait_done(tgt);

        load_key(seq_key, some_gap, 1'b0, 1'b1, 1'b0);
        tgt++;
        wait_done(tgt);

        for (int n = 0; n < 3; n++) begin
            for (int m = 0; m < C; m++) begin
                rnd_key[m] = $urandom;
                rnd_gap[m] = 4'($urandom_range(0, 3));
            end
            load_key(rnd_key, rnd_gap, 1'b0, 1'b1, 1'b1);
            tgt++;
            wait_done(tgt);
        end

        // Abort in the middle of the mix, then a clean zero-key run.
        load_key(zero_key, no_gap, 1'b1, 1'b1, 1'b0);
        repeat (66) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        void'(sb_q.pop_back());
        @(posedge clk);
        #1;
        check("abort_ready", ready, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_key_ready", key_ready, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        load_key(zero_key, no_gap, 1'b1, 1'b0, 1'b0);
        tgt++;
        wait_done(tgt);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rc5_key_expand.md
Name: rc5_key_expand

Overview:
- RC5 key-schedule stage directly upstream of the RC5 decipher/cipher datapath.
- Accepts a secret key as word-serial input, builds the expanded table S[0..t-1] with the standard RC5 init and 3-pass mix, then serves it.
- Read port is a pair port. S_address returns S[S_address] and S[S_address+1]. The datapath drives S_address = 2*i and consumes the S_sub_i1 / S_sub_i2 pair.

Parameters:
- w, 32, word width in bits (power of 2).
- r, 12, number of rounds.
- t, 2*r+2 = 26, S table entries.
- b, 16, key length in bytes.
- c, max(1, ceil(b*8/w)) = 4, key words in L.
- t_length, $clog2(t) = 5, S address width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- key_word  in  w  key word L[j], little-endian packing of key bytes.
- key_valid  in  1  key_word is valid this cycle.
- key_ready  out  1  block accepts key words (IDLE, LOAD or DONE).
- busy  out  1  high in INIT or MIX.
- ready  out  1  S table complete and valid; level signal.
- S_address  in  t_length  even index 2*i into S.
- S_sub_i1  out  w  S[S_address].
- S_sub_i2  out  w  S[S_address+1].

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE, key_ready=1, busy=0, ready=0.
  - Counters i, j, k and registers A, B cleared to 0.
  - S and L contents are don't-care.
  - Reset mid-LOAD, INIT or MIX aborts; ready stays 0.
- FSM IDLE -> LOAD -> INIT -> MIX -> DONE.
- IDLE/LOAD:
  - Each cycle with key_valid&&key_ready writes L[j]=key_word, j++.
  - The edge accepting word c-1 sets j=0, i=0 and enters INIT.
  - The first accepted word moves IDLE -> LOAD.
- INIT, t cycles, one entry per cycle:
  - S[0]=P32=0xB7E15163.
  - S[i]=S[i-1]+Q32 (Q32=0x9E3779B9), mod 2^w.
  - After i=t-1: A=B=0, i=j=0, k=0, go to MIX.
- MIX, exactly 3*max(t,c)=78 cycles, one iteration per cycle:
  - Anew=rotl(S[i]+A+B, 3); S[i]=Anew.
  - Bnew=rotl(L[j]+Anew+B, (Anew+B) mod w); L[j]=Bnew.
  - A=Anew, B=Bnew.
  - i=(i+1) mod t, j=(j+1) mod c; both wrap independently.
  - All additions are mod 2^w. The rotate amount uses the low log2(w) bits of the sum.
  - When k==3*max(t,c)-1, go to DONE.
- Latency: ready rises on the edge t+3*max(t,c)+1 = 105 clocks after the edge that accepted the last key word.
- DONE:
  - ready=1, key_ready=1.
  - Read port is combinational from S_address.
  - If S_address >= t-1, S_sub_i2=0. If S_address >= t, both outputs are 0.
- Outputs outside DONE: S_sub_i1 and S_sub_i2 are forced to 0 whenever ready=0.
- Rekey: key_valid while in DONE drops ready on the same edge, writes L[0] and enters LOAD.
- key_valid during INIT/MIX: ignored (key_ready=0). No word is lost-counted.
- key_valid low mid-LOAD: stall; j holds and no timeout applies.
- key_valid while rst==0: ignored, reset wins.

Decomposition:
- Package rc5_pkg holds:
  - P32 and Q32 constants.
  - State enum IDLE/LOAD/INIT/MIX/DONE.
  - Function for c=max(1,ceil(8b/w)).
- Sub-module rc5_rotl: parameter w; inputs x[w-1:0] and amt[$clog2(w)-1:0]; output y. Combinational barrel left-rotate.
- rc5_rotl is reusable by the cipher side; the decipher side needs rotr.

Test Plan:
- Reset behaviour: hold rst=0 for 3 cycles while driving key_valid=1 -> key_ready=1, busy=0, ready=0, S_sub_i1=S_sub_i2=0.
- Zero key and latency: load 4 words of 0x00000000 -> busy for 104 cycles, ready rises exactly 105 edges after the last word is accepted. S_address 0..24 readback matches the software model. Chained decipher of (A,B)=(0xEEDBA521,0x6D8F4B15) yields (0,0).
- Stalled load: key_valid gaps of 0, 1 and 5 cycles between 4 words of 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C -> S identical to the gap-free load and to the model.
- Rekey: in DONE, load a new key -> ready falls on the first new word. The new S matches the model, and no stale entry is readable while ready=0.
- Abort: assert rst=0 at MIX iteration 40, then reload the zero key -> ready only after a full 105-cycle run, and S matches the zero-key case.
- Bounds and ignore: read with S_address=24 returns S[24] and S[25]. S_address=26..31 returns 0 and 0. key_valid pulses during INIT/MIX do not change the final S.
